// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// funct codes, ALUOp and the ALUControl codes the ALU decodes.
package mips_defs;

    localparam logic [3:0] ST_FETCH   = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_MEMADR  = 4'd2;
    localparam logic [3:0] ST_MEMRD   = 4'd3;
    localparam logic [3:0] ST_MEMWB   = 4'd4;
    localparam logic [3:0] ST_MEMWR   = 4'd5;
    localparam logic [3:0] ST_RTYPEEX = 4'd6;
    localparam logic [3:0] ST_RTYPEWB = 4'd7;
    localparam logic [3:0] ST_BEQEX   = 4'd8;
    localparam logic [3:0] ST_ADDIEX  = 4'd9;
    localparam logic [3:0] ST_ADDIWB  = 4'd10;
    localparam logic [3:0] ST_JEX     = 4'd11;

    typedef enum logic [3:0] {
        FETCH   = ST_FETCH,
        DECODE  = ST_DECODE,
        MEMADR  = ST_MEMADR,
        MEMRD   = ST_MEMRD,
        MEMWB   = ST_MEMWB,
        MEMWR   = ST_MEMWR,
        RTYPEEX = ST_RTYPEEX,
        RTYPEWB = ST_RTYPEWB,
        BEQEX   = ST_BEQEX,
        ADDIEX  = ST_ADDIEX,
        ADDIWB  = ST_ADDIWB,
        JEX     = ST_JEX
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps ALUOp and the R-type funct field onto ALUControl.
module alu_decoder
    import mips_defs::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALUC_AND;
        case (aluop)
            ALUOP_ADD: alucontrol = ALUC_ADD;
            ALUOP_SUB: alucontrol = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALUC_ADD;
                    FN_SUB:  alucontrol = ALUC_SUB;
                    FN_AND:  alucontrol = ALUC_AND;
                    FN_OR:   alucontrol = ALUC_OR;
                    FN_SLT:  alucontrol = ALUC_SLT;
                    default: alucontrol = ALUC_AND;
                endcase
            end
            default: alucontrol = ALUC_AND;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Define MC_CTRL_MEM_HANDSHAKE_EN to let mem_ready
// stall FETCH/MEMRD/MEMWR; otherwise every memory access completes in one cycle.
//
// state   | meaning
// FETCH   | read instruction at PC, PC += 4
// DECODE  | branch target into ALUOut, dispatch on Op
// MEMADR  | compute lw/sw effective address
// MEMRD   | read data memory
// MEMWB   | write MDR to rt
// MEMWR   | write data memory
// RTYPEEX | ALU op on A, B
// RTYPEWB | write ALUOut to rd
// BEQEX   | compare A, B; take branch on Zero
// ADDIEX  | A + SignImm
// ADDIWB  | write ALUOut to rt
// JEX     | load jump target into PC
module mips_multicycle_ctrl
    import mips_defs::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [2:0] ALUControl,
    output logic       illegal_op
);

    state_t     state;
    logic       mem_go;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
    logic       memwrite_s;
    logic       irwrite_s;
    logic       regwrite_s;

`ifdef MC_CTRL_MEM_HANDSHAKE_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = mem_ready | 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   if (mem_go) state <= DECODE;
                DECODE: begin
                    case (Op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= RTYPEEX;
                        OP_BEQ:       state <= BEQEX;
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JEX;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:  state <= (Op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   if (mem_go) state <= MEMWB;
                MEMWB:   state <= FETCH;
                MEMWR:   if (mem_go) state <= FETCH;
                RTYPEEX: state <= RTYPEWB;
                RTYPEWB: state <= FETCH;
                BEQEX:   state <= FETCH;
                ADDIEX:  state <= ADDIWB;
                ADDIWB:  state <= FETCH;
                JEX:     state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        IorD       = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        regwrite_s = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        PCSrc      = PCSRC_ALU;
        aluop      = ALUOP_ADD;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                irwrite_s = mem_go;
                pcwrite   = mem_go;
            end
            DECODE: begin
                ALUSrcB = SRCB_IMMSH2;
                case (Op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                    default: illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            MEMRD:   IorD = 1'b1;
            MEMWB: begin
                MemtoReg   = 1'b1;
                regwrite_s = 1'b1;
            end
            MEMWR: begin
                IorD       = 1'b1;
                memwrite_s = 1'b1;
            end
            RTYPEEX: begin
                ALUSrcA = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                RegDst     = 1'b1;
                regwrite_s = 1'b1;
            end
            BEQEX: begin
                ALUSrcA = 1'b1;
                aluop   = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ADDIWB:  regwrite_s = 1'b1;
            JEX: begin
                PCSrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are killed combinationally so nothing fires while reset is held.
    assign MemWrite = memwrite_s & rst_n;
    assign IRWrite  = irwrite_s & rst_n;
    assign RegWrite = regwrite_s & rst_n;
    assign PCEn     = (pcwrite | (branch & Zero)) & rst_n;

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (Funct),
        .alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle control-vector model plus
// literal checks on write-back cycle, exec ALUControl and reset forcing.
module tb_mips_multicycle_ctrl;

`ifdef MC_CTRL_MEM_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, illegal_op;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [2:0] aluctl;
        logic       illegal;
    } ctl_t;

    ctl_t  act;
    ctl_t  exp_c;
    bit    exp_valid;
    string tag;
    int    checks;
    int    failures;
    int    cyc;
    int    wb_cyc;
    logic [2:0] ex_alu;
    logic       ex_pcen;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .PCEn       (PCEn),
        .ALUControl (ALUControl),
        .illegal_op (illegal_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb act = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                       ALUSrcB, PCSrc, PCEn, ALUControl, illegal_op};

    function automatic ctl_t idle();
        ctl_t c = '0;
        c.aluctl = 3'd2;
        return c;
    endfunction

    function automatic logic [2:0] alu_for_funct(input logic [5:0] f);
        if (f == 6'd32) return 3'd2;
        if (f == 6'd34) return 3'd6;
        if (f == 6'd36) return 3'd0;
        if (f == 6'd37) return 3'd1;
        if (f == 6'd42) return 3'd7;
        return 3'd0;
    endfunction

    // Control vector a cycle of the named instruction step must show.
    function automatic ctl_t expect_step(input string step, input logic mr, input logic z,
                                         input logic [5:0] f, input logic ill);
        ctl_t c = idle();
        logic go = HS ? mr : 1'b1;
        if (step == "fetch") begin
            c.alusrcb = 2'd1; c.irwrite = go; c.pcen = go;
        end else if (step == "decode") begin
            c.alusrcb = 2'd3; c.illegal = ill;
        end else if (step == "memadr" || step == "addiex") begin
            c.alusrca = 1'b1; c.alusrcb = 2'd2;
        end else if (step == "memrd") begin
            c.iord = 1'b1;
        end else if (step == "memwb") begin
            c.memtoreg = 1'b1; c.regwrite = 1'b1;
        end else if (step == "memwr") begin
            c.iord = 1'b1; c.memwrite = 1'b1;
        end else if (step == "rtypeex") begin
            c.alusrca = 1'b1; c.aluctl = alu_for_funct(f);
        end else if (step == "rtypewb") begin
            c.regdst = 1'b1; c.regwrite = 1'b1;
        end else if (step == "beqex") begin
            c.alusrca = 1'b1; c.pcsrc = 2'd1; c.pcen = z; c.aluctl = 3'd6;
        end else if (step == "addiwb") begin
            c.regwrite = 1'b1;
        end else if (step == "jex") begin
            c.pcsrc = 2'd2; c.pcen = 1'b1;
        end else if (step == "reset") begin
            c.alusrcb = 2'd1;
        end
        return c;
    endfunction

    function automatic bit is_known_op(input logic [5:0] o);
        return o == 6'd35 || o == 6'd43 || o == 6'd0 || o == 6'd4 || o == 6'd8 || o == 6'd2;
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (act !== exp_c) begin
                failures++;
                $display("FAIL step_%s got=%h want=%h", tag, act, exp_c);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic cycle(input string step, input logic mr, input logic z);
        mem_ready = mr;
        Zero      = z;
        tag       = step;
        exp_c     = expect_step(step, mr, z, Funct, !is_known_op(Op));
        exp_valid = 1'b1;
        cyc++;
        #2;
        if (RegWrite === 1'b1 && wb_cyc == 0) wb_cyc = cyc;
        if (step == "rtypeex" || step == "beqex") begin
            ex_alu  = ALUControl;
            ex_pcen = PCEn;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fwait, input int mwait, input int want_wb,
                             input logic [2:0] want_alu);
        Op = op; Funct = fn; cyc = 0; wb_cyc = 0;
        if (HS) for (int i = 0; i < fwait; i++) cycle("fetch", 1'b0, ~z);
        cycle("fetch", (!HS && fwait > 0) ? 1'b0 : 1'b1, ~z);
        cycle("decode", 1'b1, ~z);
        if (op == 6'd35 || op == 6'd43) begin
            cycle("memadr", 1'b1, ~z);
            if (HS) for (int i = 0; i < mwait; i++) cycle(op == 6'd35 ? "memrd" : "memwr", 1'b0, ~z);
            cycle(op == 6'd35 ? "memrd" : "memwr", (!HS && mwait > 0) ? 1'b0 : 1'b1, ~z);
            if (op == 6'd35) cycle("memwb", 1'b1, ~z);
        end else if (op == 6'd0) begin
            cycle("rtypeex", 1'b1, ~z);
            cycle("rtypewb", 1'b1, ~z);
            chk("rtype_aluctl", {5'd0, ex_alu}, {5'd0, want_alu});
        end else if (op == 6'd4) begin
            cycle("beqex", 1'b1, z);
            chk("beq_aluctl", {5'd0, ex_alu}, {5'd0, want_alu});
            chk("beq_pcen", {7'd0, ex_pcen}, {7'd0, z});
        end else if (op == 6'd8) begin
            cycle("addiex", 1'b1, ~z);
            cycle("addiwb", 1'b1, ~z);
        end else if (op == 6'd2) begin
            cycle("jex", 1'b1, ~z);
        end
        chk("regwrite_cycle", wb_cyc[7:0], want_wb[7:0]);
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; wb_cyc = 0;
        ex_alu = '0; ex_pcen = 1'b0;
        rst_n = 1'b0; Op = 6'd0; Funct = 6'd0; Zero = 1'b0; mem_ready = 1'b1;
        tag = "reset"; exp_c = expect_step("reset", 1'b1, 1'b0, 6'd0, 1'b0); exp_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 4, 3'b010);
        run_instr(6'b000000, 6'b101010, 1'b0, 0, 0, 4, 3'b111);
        run_instr(6'b000000, 6'b100010, 1'b1, 0, 0, 4, 3'b110);
        run_instr(6'b000000, 6'b100100, 1'b0, 0, 0, 4, 3'b000);
        run_instr(6'b000000, 6'b100101, 1'b0, 0, 0, 4, 3'b001);
        run_instr(6'b000000, 6'b111111, 1'b0, 2, 0, HS ? 6 : 4, 3'b000);
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 3, HS ? 8 : 5, 3'b010);
        run_instr(6'b101011, 6'b000000, 1'b1, 0, 2, 0, 3'b010);
        run_instr(6'b001000, 6'b101010, 1'b0, 0, 0, 4, 3'b010);
        run_instr(6'b000100, 6'b100101, 1'b1, 0, 0, 0, 3'b110);
        run_instr(6'b000100, 6'b100101, 1'b0, 0, 0, 0, 3'b110);
        run_instr(6'b000010, 6'b000000, 1'b1, 0, 0, 0, 3'b010);
        run_instr(6'b111111, 6'b000000, 1'b1, 0, 0, 0, 3'b010);
        run_instr(6'b100011, 6'b101010, 1'b0, 1, 0, HS ? 6 : 5, 3'b010);

        // Abandon a lw in MEMRD with an asynchronous reset pulse.
        Op = 6'b100011; Funct = 6'b100010; cyc = 0; wb_cyc = 0;
        cycle("fetch", 1'b1, 1'b0);
        cycle("decode", 1'b1, 1'b0);
        cycle("memadr", 1'b1, 1'b0);
        mem_ready = 1'b0;
        exp_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        tag   = "reset";
        exp_c = expect_step("reset", 1'b1, 1'b0, Funct, 1'b0);
        exp_valid = 1'b1;
        #1;
        chk("rst_memwrite", {7'd0, MemWrite}, 8'd0);
        chk("rst_irwrite",  {7'd0, IRWrite},  8'd0);
        chk("rst_regwrite", {7'd0, RegWrite}, 8'd0);
        chk("rst_pcen",     {7'd0, PCEn},     8'd0);
        chk("rst_aluctl",   {5'd0, ALUControl}, 8'd2);
        @(posedge clk); #1;
        mem_ready = 1'b1; Zero = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_instr(6'b001000, 6'b000000, 1'b0, 0, 0, 4, 3'b010);
        Op = 6'b000000;
        cycle("fetch", 1'b1, 1'b0);
        exp_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Control unit for the multicycle MIPS datapath. It is the producing end of the 3-bit `ALUControl` bus consumed by the ALU. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback. Per state it drives the datapath mux selects and write enables, and an ALU decoder turns `ALUOp`/`Funct` into `ALUControl`. It sits between the instruction register fields and the shared datapath (PC, IR, register file, ALU, unified memory).

## Interface
Parameters: none (all encodings come from the shared package).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Op`  in  6  IR[31:26].
- `Funct`  in  6  IR[5:0].
- `Zero`  in  1  ALU result == 0 (computed outside the ALU).
- `mem_ready`  in  1  memory access completes this cycle.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  memory write enable.
- `IRWrite`  out  1  instruction register load.
- `RegDst`  out  1  write register: 0 = rt, 1 = rd.
- `MemtoReg`  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- `RegWrite`  out  1  register file write enable.
- `ALUSrcA`  out  1  ALU A operand: 0 = PC, 1 = register A.
- `ALUSrcB`  out  2  ALU B operand: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `PCSrc`  out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `PCEn`  out  1  PC load = PCWrite | (Branch & Zero).
- `ALUControl`  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `illegal_op`  out  1  high in DECODE when `Op` is unsupported.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite=PCWrite=`mem_ready`. Go to DECODE on `mem_ready`, else hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by `Op`:
  - lw 100011 / sw 101011 → MEMADR
  - R-type 000000 → RTYPEEX
  - beq 000100 → BEQEX
  - addi 001000 → ADDIEX
  - j 000010 → JEX
  - other → FETCH, with illegal_op=1 for that cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, then FETCH.
- MEMWR: IorD=1, MemWrite=1. Hold until `mem_ready`, then FETCH. MemWrite stays high for the whole hold.
- RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then RTYPEWB.
- RTYPEWB: RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
- BEQEX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, then FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00, then ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, then FETCH.
- JEX: PCSrc=10, PCWrite=1, then FETCH.
- Unlisted outputs are 0 in every state.
- ALU decoder:
  - ALUOp 00 → 010; 01 → 110.
  - ALUOp 10 by `Funct`: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, other→000.
  - ALUOp 11 → 000.

## Timing
- State is registered; all outputs are combinational from state (plus `Zero` for PCEn, `mem_ready` for FETCH enables, `Op`/`Funct` for ALUControl and illegal_op).
- Reset: while `rst_n`=0, state=FETCH and MemWrite, IRWrite, RegWrite and PCEn are forced to 0. Other outputs take their FETCH values: ALUSrcB=01, ALUControl=010, all remaining selects 0.
- A reset asserted mid-instruction abandons it. The first rising edge after release starts in FETCH.
- Cycles per instruction with `mem_ready` always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each extra low cycle of `mem_ready` in FETCH, MEMRD or MEMWR adds one cycle.
- `Zero` is sampled only in BEQEX. PCEn there equals `Zero` in the same cycle.

## Configuration
- `MC_CTRL_MEM_HANDSHAKE_EN` defined: `mem_ready` gates FETCH, MEMRD and MEMWR exactly as described above.
- Undefined: `mem_ready` is ignored and treated as constant 1. Each of those states lasts exactly one cycle, and IRWrite/PCWrite in FETCH are unconditionally 1 outside reset.

## Structure
- Shared package `mips_defs`:
  - state encodings (4-bit localparams)
  - opcode and funct constants
  - ALUOp codes
  - ALUControl codes, which the ALU also uses
- One sub-module, `alu_decoder` (ALUOp, Funct → ALUControl), purely combinational.
- The FSM (next-state logic plus output decode) stays in `mips_multicycle_ctrl`.

## Test plan
- Reset pulse mid-MEMRD: `rst_n` low → MemWrite, IRWrite, RegWrite, PCEn = 0 immediately, ALUControl=010. First edge after release is in FETCH.
- R-type `add`, then `slt` (Funct 100000, then 101010), `mem_ready`=1 → RTYPEEX shows ALUControl 010, then 111. RegWrite=1 and RegDst=1 exactly in cycle 4.
- lw with `mem_ready` low for 3 cycles in MEMRD → stays in MEMRD for 4 cycles. RegWrite with MemtoReg=1 in cycle 8. sw holds MemWrite=1 for its whole wait.
- beq with `Zero`=1, then `Zero`=0 → PCEn=1 with PCSrc=01 in BEQEX, then PCEn=0. ALUControl=110 in both.
- Op=111111 → illegal_op=1 for one cycle in DECODE, then FETCH with no RegWrite or MemWrite.
- Handshake macro undefined, `mem_ready` held 0 → lw still completes in 5 cycles.
